// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_cmd_decoder                                                |
// | Purpose  : Assembles SYNC/CMD/DATA/CHK byte frames from a UART receiver    |
// |            and issues single-cycle register write/read strobes. Frames    |
// |            with a bad checksum or an inter-byte timeout are rejected and  |
// |            counted in a saturating error counter.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Wr_En,
  output logic       o_Rd_En,
  output logic [6:0] o_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Chk_Err,
  output logic       o_Timeout_Err,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_CMD   = 2'd1,
    GET_DATA  = 2'd2,
    GET_CHK   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [7:0]  r_cmd;
  logic [7:0]  r_data;

  logic        w_timeout;
  logic [7:0]  w_expected;
  logic        w_chk_ok;
  logic [7:0]  w_err_next;

  // A timeout only counts on an idle cycle; a byte arriving on the limit cycle wins
  assign w_timeout  = (r_state != WAIT_SYNC) && !i_RX_DV &&
                      (r_timer == (TIMEOUT_CYCLES - 16'd1));
  // Write frames protect CMD and DATA, read frames just repeat CMD
  assign w_expected = r_cmd[7] ? (r_cmd ^ r_data) : r_cmd;
  assign w_chk_ok   = (i_RX_Byte == w_expected);
  assign w_err_next = (o_Err_Count == 8'hFF) ? 8'hFF : (o_Err_Count + 8'd1);

  // Frame FSM, inter-byte timer and all registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= WAIT_SYNC;
      r_timer       <= 16'd0;
      r_cmd         <= 8'd0;
      r_data        <= 8'd0;
      o_Wr_En       <= 1'b0;
      o_Rd_En       <= 1'b0;
      o_Addr        <= 7'd0;
      o_Wr_Data     <= 8'd0;
      o_Chk_Err     <= 1'b0;
      o_Timeout_Err <= 1'b0;
      o_Err_Count   <= 8'd0;
      o_Busy        <= 1'b0;
    end else begin
      o_Wr_En       <= 1'b0;
      o_Rd_En       <= 1'b0;
      o_Chk_Err     <= 1'b0;
      o_Timeout_Err <= 1'b0;

      if ((r_state == WAIT_SYNC) || i_RX_DV) begin
        r_timer <= 16'd0;
      end else begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_timeout) begin
        r_state       <= WAIT_SYNC;
        o_Busy        <= 1'b0;
        o_Timeout_Err <= 1'b1;
        o_Err_Count   <= w_err_next;
      end else begin
        case (r_state)
          WAIT_SYNC: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
              r_state <= GET_CMD;
              o_Busy  <= 1'b1;
            end
          end
          GET_CMD: begin
            // A CMD byte equal to SYNC_BYTE is still a CMD; there is no resync
            if (i_RX_DV) begin
              r_cmd   <= i_RX_Byte;
              r_state <= i_RX_Byte[7] ? GET_DATA : GET_CHK;
            end
          end
          GET_DATA: begin
            if (i_RX_DV) begin
              r_data  <= i_RX_Byte;
              r_state <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (i_RX_DV) begin
              r_state <= WAIT_SYNC;
              o_Busy  <= 1'b0;
              if (w_chk_ok) begin
                o_Addr <= r_cmd[6:0];
                if (r_cmd[7]) begin
                  o_Wr_Data <= r_data;
                  o_Wr_En   <= 1'b1;
                end else begin
                  o_Rd_En   <= 1'b1;
                end
              end else begin
                o_Chk_Err   <= 1'b1;
                o_Err_Count <= w_err_next;
              end
            end
          end
          default: begin
            r_state <= WAIT_SYNC;
            o_Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle data-valid pulse and byte, assembles sync/command/data/checksum frames, and issues single-cycle register write or read requests to the register file. It rejects malformed frames: bad checksum, or an inter-byte timeout. It counts the rejected frames in a saturating error counter.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 16'd50000, maximum idle clocks between bytes inside a frame (must be ≥ 2).
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Rst_L  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- i_RX_DV  in  1  one-cycle pulse, byte valid from UART receiver.
- i_RX_Byte  in  8  received byte, valid when i_RX_DV=1.
- o_Wr_En  out  1  one-cycle register write strobe.
- o_Rd_En  out  1  one-cycle register read strobe.
- o_Addr  out  7  register address of last accepted command.
- o_Wr_Data  out  8  write data of last accepted write.
- o_Chk_Err  out  1  one-cycle pulse, checksum mismatch.
- o_Timeout_Err  out  1  one-cycle pulse, inter-byte timeout.
- o_Err_Count  out  8  saturating count of rejected frames.
- o_Busy  out  1  high whenever the state is not WAIT_SYNC.

## Operation
- Write frame: SYNC_BYTE, CMD (bit7=1, bits[6:0]=addr), DATA, CHK = CMD ^ DATA.
- Read frame: SYNC_BYTE, CMD (bit7=0, bits[6:0]=addr), CHK = CMD.
- States: WAIT_SYNC, GET_CMD, GET_DATA, GET_CHK. Unused encodings go to WAIT_SYNC.
- WAIT_SYNC: on DV with byte == SYNC_BYTE, go to GET_CMD. Any other byte is ignored silently, with no error.
- GET_CMD: on DV, latch the byte into the internal cmd register. If bit7=1, go to GET_DATA, else go to GET_CHK. A CMD byte equal to SYNC_BYTE is treated as a CMD. There is no resync.
- GET_DATA: on DV, latch the byte into the internal data register and go to GET_CHK.
- GET_CHK: on DV, compute the expected value: cmd^data for a write, cmd for a read.
  - Match: o_Addr <= cmd[6:0]. On a write, also o_Wr_Data <= data and pulse o_Wr_En; on a read, pulse o_Rd_En instead.
  - Mismatch: pulse o_Chk_Err and increment o_Err_Count. o_Addr and o_Wr_Data are not updated.
  - Either case: return to WAIT_SYNC.
- Timeout counter (16 bit):
  - Cleared on every DV and whenever the state is WAIT_SYNC.
  - Increments each clock in the other states.
  - When it reaches TIMEOUT_CYCLES-1 with no DV that cycle: go to WAIT_SYNC, pulse o_Timeout_Err, increment o_Err_Count.
- Simultaneous DV and timeout in the same cycle: the DV wins, the byte is processed normally, and no timeout is signalled.
- o_Err_Count saturates at 8'hFF. It clears only on reset.
- o_Addr and o_Wr_Data hold their value until the next accepted command of the corresponding type updates them.

## Timing
- Reset values (asynchronous, i_Rst_L=0): state WAIT_SYNC, all strobes 0, o_Addr 0, o_Wr_Data 0, o_Err_Count 0, timeout counter 0, internal cmd/data 0, o_Busy 0.
- Reset mid-frame aborts the frame immediately. No strobe or error is issued.
- All outputs are registered.
- o_Wr_En, o_Rd_En and o_Chk_Err rise on the clock edge after the cycle in which the CHK byte's DV is sampled, and last exactly 1 cycle.
- o_Addr and o_Wr_Data are valid in the same cycle as o_Wr_En / o_Rd_En.
- o_Timeout_Err rises on the edge after the counter is sampled at TIMEOUT_CYCLES-1, and lasts 1 cycle.
- o_Err_Count updates in the same cycle the error pulse is high.
- o_Busy goes high the cycle after the SYNC DV, and goes low in the same cycle a strobe or error pulse is high.
- Back-to-back frames are accepted with no gap: a SYNC byte arriving on the cycle after the CHK byte is recognised. The upstream receiver spaces DV pulses at least 10 bit-times apart, but the decoder also handles DV on consecutive cycles.

## Test plan
- Write: bytes A5, 85, 3C, B9 -> single o_Wr_En pulse with o_Addr=0x05, o_Wr_Data=0x3C. No error; o_Err_Count=0.
- Read: bytes A5, 12, 12 -> single o_Rd_En pulse with o_Addr=0x12. o_Wr_Data is unchanged from the previous value.
- Bad checksum: A5, 85, 3C, 00 -> o_Chk_Err pulse, no o_Wr_En, o_Err_Count=1, o_Addr/o_Wr_Data unchanged. A following valid write frame is then accepted.
- Garbage and timeout: bytes 00, FF (ignored, o_Busy stays 0), then A5, 85, then silence for TIMEOUT_CYCLES (set to 20). Required response: o_Timeout_Err pulses exactly 20 cycles after the DV of the 85 byte, o_Err_Count increments, o_Busy drops. A DV placed exactly on the timeout cycle must instead be processed as DATA.
- Saturation: 300 bad-checksum frames -> o_Err_Count stops at 0xFF.
- Reset mid-frame: A5, 85, then i_Rst_L low for 1 cycle, then 3C, B9 -> no strobe and no error. The decoder is in WAIT_SYNC, and all outputs are at their reset values.
